hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised scoreboard-based hazard and stall controller for the pipelined MIPS core; sits beside the decode stage.
- Tracks every in-flight register write with a per-register countdown and stalls decode on RAW hazards.
- Freezes the whole pipeline while data memory is busy and absorbs decode squashes.
- Keeps a small run/hazard/freeze state machine and a stall performance counter.

Parameters:
- NREGS, 32, architectural register count; register 0 is never tracked.
- REGW, 5, register index width, equal to clog2(NREGS).
- WB_LAT, 3, cycles from issue to register-file write; must be 2..7.
- PERFW, 16, width of the stall-cycle counter.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iss_valid  in  1  decode holds a valid instruction.
- iss_rs  in  REGW  source register rs.
- iss_rt  in  REGW  source register rt.
- iss_use_rs  in  1  instruction reads rs.
- iss_use_rt  in  1  instruction reads rt.
- iss_wen  in  1  instruction writes iss_dest.
- iss_dest  in  REGW  destination register.
- iss_load  in  1  instruction is a load (LW).
- iss_flush  in  1  squash the decode instruction this cycle (taken branch/jump).
- mem_wait  in  1  data memory has not completed; pipeline must hold.
- stall  out  1  hold fetch/decode and insert a bubble into execute.
- freeze  out  1  hold every pipeline register.
- issued  out  1  decode instruction accepted this cycle.
- state  out  2  0=RUN, 1=HAZ, 2=FREEZE.
- stall_cycles  out  PERFW  saturating count of cycles with stall or freeze high.

Behaviour:
- Storage per register r = 1..NREGS-1: cnt[r] of width clog2(WB_LAT+1), plus load flag ld[r].
- ready(r):
  - r == 0, or cnt[r] == 0.
  - Under FWD_EN, also: ld[r] == 0, or cnt[r] <= WB_LAT-1.
- hazard = iss_valid & !iss_flush & ((iss_use_rs & !ready(iss_rs)) | (iss_use_rt & !ready(iss_rt))).
- Combinational outputs:
  - freeze = mem_wait.
  - stall = hazard | mem_wait.
  - issued = iss_valid & !iss_flush & !stall.
- Each clock edge with freeze low:
  - Every nonzero cnt decrements by 1.
  - When cnt reaches 0, ld clears.
  - If issued & iss_wen & iss_dest != 0: cnt[iss_dest] <= WB_LAT and ld[iss_dest] <= iss_load. This overrides the decrement of the same register (WAW: newest writer wins).
- With freeze high, all cnt/ld hold and no issue is recorded.
- Flushed instructions never update the scoreboard. The flush wins over a simultaneous hazard (stall drops unless mem_wait).
- FSM, registered; the next state is evaluated every cycle:
  - Any state -> FREEZE when mem_wait.
  - Else -> HAZ when hazard.
  - Else -> RUN.
  - FREEZE -> HAZ is direct when mem_wait falls while a hazard persists.
- stall_cycles increments on each edge where stall is high, and saturates at 2^PERFW-1.
- Reset (nRST low, asynchronous) clears:
  - all cnt and ld;
  - state=RUN;
  - stall_cycles=0.
- With all inputs low, stall=freeze=issued=0 during and after reset.
- Reset mid-stall discards every pending write, so decode becomes ready immediately after nRST rises.
- WB_LAT values outside 2..7 are a configuration error, flagged with an elaboration-time assertion.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_FWD_EN.
- Defined (datapath has EX/MEM->EX forwarding):
  - Non-load producers never cause a stall.
  - A load stalls a dependent only while cnt == WB_LAT, i.e. exactly one bubble for back-to-back load-use.
  - ld storage is implemented.
- Undefined: any pending write (cnt != 0) stalls its readers; ld storage is not implemented and iss_load is ignored.

Test Plan:
- Reset: hold nRST=0 with iss_valid=1 reading $5 -> stall=0, issued=1, state=RUN, stall_cycles=0.
- ALU RAW, no FWD:
  - Cycle 0 issues add $3 (wen, dest=3).
  - Cycle 1 presents sub reading rs=$3 -> stall=1 for WB_LAT=3 cycles, state=HAZ.
  - issued=1 on cycle 4.
  - stall_cycles=3.
- Load-use with FWD_EN:
  - lw $4 is issued; the next instruction reads rt=$4 -> exactly one stall cycle.
  - An add producer followed by a dependent -> zero stalls.
- mem_wait during hazard:
  - mem_wait=1 for 2 cycles while cnt[$3]=2 -> freeze=1, state=FREEZE, cnt held at 2.
  - After release, stall continues 2 more cycles.
- Flush and $0:
  - iss_flush=1 on a dependent instruction -> stall=0, issued=0, scoreboard unchanged.
  - Writes to $0 are never tracked; reads of $0 never stall.
- WAW and saturation:
  - Two writes to $7 issued 1 cycle apart -> cnt[$7] reloads to 3, and a reader waits for the second.
  - PERFW=4 with 20 stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register write scoreboard that stalls decode on RAW
//               hazards, freezes the pipeline on data-memory wait and counts
//               stall cycles. Define HAZARD_SCOREBOARD_FWD_EN when the
//               datapath forwards EX/MEM results into EX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int NREGS  = 32,
    parameter int REGW   = 5,
    parameter int WB_LAT = 3,
    parameter int PERFW  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iss_valid,
    input  logic [REGW-1:0]  iss_rs,
    input  logic [REGW-1:0]  iss_rt,
    input  logic             iss_use_rs,
    input  logic             iss_use_rt,
    input  logic             iss_wen,
    input  logic [REGW-1:0]  iss_dest,
    input  logic             iss_load,
    input  logic             iss_flush,
    input  logic             mem_wait,
    output logic             stall,
    output logic             freeze,
    output logic             issued,
    output logic [1:0]       state,
    output logic [PERFW-1:0] stall_cycles
);

    localparam int CW = $clog2(WB_LAT + 1);
    localparam logic [CW-1:0]    c_lat      = CW'(WB_LAT);
    localparam logic [CW-1:0]    c_cnt_one  = CW'(1);
    localparam logic [PERFW-1:0] c_perf_one = PERFW'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HAZ    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    generate
        if (WB_LAT < 2 || WB_LAT > 7) begin : g_bad_wb_lat
            $error("hazard_scoreboard: WB_LAT must be in 2..7");
        end
        if ((1 << REGW) < NREGS) begin : g_bad_regw
            $error("hazard_scoreboard: REGW too narrow for NREGS");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt [NREGS];
    logic [PERFW-1:0] r_stall_cycles;

    logic w_rs_rdy;
    logic w_rt_rdy;
    logic w_live;
    logic w_hazard;
    logic w_stall;
    logic w_issued;
    logic w_alloc;

`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam logic [CW-1:0] c_lat_m1 = CW'(WB_LAT - 1);
    logic [NREGS-1:0] r_ld;

    // A forwarded producer is usable unless it is a load still in EX.
    assign w_rs_rdy = (iss_rs == '0) || (r_cnt[iss_rs] == '0) ||
                      !r_ld[iss_rs] || (r_cnt[iss_rs] <= c_lat_m1);
    assign w_rt_rdy = (iss_rt == '0) || (r_cnt[iss_rt] == '0) ||
                      !r_ld[iss_rt] || (r_cnt[iss_rt] <= c_lat_m1);
`else
    logic w_unused_load;
    assign w_unused_load = iss_load;

    assign w_rs_rdy = (iss_rs == '0) || (r_cnt[iss_rs] == '0);
    assign w_rt_rdy = (iss_rt == '0) || (r_cnt[iss_rt] == '0);
`endif

    assign w_live   = iss_valid && !iss_flush;
    assign w_hazard = w_live && ((iss_use_rs && !w_rs_rdy) ||
                                 (iss_use_rt && !w_rt_rdy));
    assign w_stall  = w_hazard || mem_wait;
    assign w_issued = w_live && !w_stall;
    assign w_alloc  = w_issued && iss_wen && (iss_dest != '0);

    assign freeze       = mem_wait;
    assign stall        = w_stall;
    assign issued       = w_issued;
    assign state        = r_state;
    assign stall_cycles = r_stall_cycles;

    // Entry 0 is only ever cleared by reset, so $0 always reads as ready.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= '0;
            end
`ifdef HAZARD_SCOREBOARD_FWD_EN
            r_ld <= '0;
`endif
        end else if (!mem_wait) begin
            for (int r = 1; r < NREGS; r++) begin
                if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - c_cnt_one;
                end
`ifdef HAZARD_SCOREBOARD_FWD_EN
                if (r_cnt[r] == c_cnt_one) begin
                    r_ld[r] <= 1'b0;
                end
`endif
            end
            // Newest writer overrides the countdown of an older one.
            if (w_alloc) begin
                r_cnt[iss_dest] <= c_lat;
`ifdef HAZARD_SCOREBOARD_FWD_EN
                r_ld[iss_dest]  <= iss_load;
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (mem_wait) begin
            w_state_nxt = ST_FREEZE;
        end else if (w_hazard) begin
            w_state_nxt = ST_HAZ;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state        <= ST_RUN;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cycles != {PERFW{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + c_perf_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, checked against a write-completion-time reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_hazard_scoreboard;

    localparam int NREGS  = 32;
    localparam int REGW   = 5;
    localparam int WB_LAT = 3;
    localparam int PERFW  = 6;
    localparam int SCMAX  = (1 << PERFW) - 1;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             iss_valid = 1'b0;
    logic [REGW-1:0]  iss_rs = '0;
    logic [REGW-1:0]  iss_rt = '0;
    logic             iss_use_rs = 1'b0;
    logic             iss_use_rt = 1'b0;
    logic             iss_wen = 1'b0;
    logic [REGW-1:0]  iss_dest = '0;
    logic             iss_load = 1'b0;
    logic             iss_flush = 1'b0;
    logic             mem_wait = 1'b0;
    logic             stall;
    logic             freeze;
    logic             issued;
    logic [1:0]       state;
    logic [PERFW-1:0] stall_cycles;

    hazard_scoreboard #(
        .NREGS (NREGS),
        .REGW  (REGW),
        .WB_LAT(WB_LAT),
        .PERFW (PERFW)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iss_valid   (iss_valid),
        .iss_rs      (iss_rs),
        .iss_rt      (iss_rt),
        .iss_use_rs  (iss_use_rs),
        .iss_use_rt  (iss_use_rt),
        .iss_wen     (iss_wen),
        .iss_dest    (iss_dest),
        .iss_load    (iss_load),
        .iss_flush   (iss_flush),
        .mem_wait    (mem_wait),
        .stall       (stall),
        .freeze      (freeze),
        .issued      (issued),
        .state       (state),
        .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wen;
        logic [4:0] dest;
        logic       ld;
    } ins_t;

    typedef struct {
        bit stall;
        bit freeze;
        bit issued;
        int state;
        int sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a write lands once 'act' (count of unfrozen edges
    // since reset) reaches wb_at; the register is pending until then.
    int unsigned act;
    int unsigned wb_at [NREGS];
    bit          is_ld [NREGS];
    int          m_state;
    int          m_sc;

    function automatic void m_reset();
        act = 0;
        for (int r = 0; r < NREGS; r++) begin
            wb_at[r] = 0;
            is_ld[r] = 1'b0;
        end
        m_state = 0;
        m_sc    = 0;
    endfunction

    function automatic bit m_ready(input int r);
        if (r == 0) return 1'b1;
        if (wb_at[r] <= act) return 1'b1;
`ifdef HAZARD_SCOREBOARD_FWD_EN
        if (!is_ld[r]) return 1'b1;
        return (wb_at[r] - act) != WB_LAT;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",        int'(stall),        int'(e.stall));
            chk("freeze",       int'(freeze),       int'(e.freeze));
            chk("issued",       int'(issued),       int'(e.issued));
            chk("state",        int'(state),        e.state);
            chk("stall_cycles", int'(stall_cycles), e.sc);
        end
    end

    // One cycle: drive just after the rising edge, predict, then advance the model.
    task automatic step(input ins_t i, input bit fl, input bit mw, input bit rn,
                        output bit iss_o);
        bit   live;
        bit   haz;
        bit   stl;
        exp_t e;
        nRST = rn;
        if (!rn) m_reset();
        iss_valid  = i.v;
        iss_rs     = i.rs;
        iss_rt     = i.rt;
        iss_use_rs = i.urs;
        iss_use_rt = i.urt;
        iss_wen    = i.wen;
        iss_dest   = i.dest;
        iss_load   = i.ld;
        iss_flush  = fl;
        mem_wait   = mw;
        live  = i.v && !fl;
        haz   = live && ((i.urs && !m_ready(int'(i.rs))) ||
                         (i.urt && !m_ready(int'(i.rt))));
        stl   = haz || mw;
        iss_o = live && !stl;
        e.stall  = stl;
        e.freeze = mw;
        e.issued = iss_o;
        e.state  = m_state;
        e.sc     = m_sc;
        q.push_back(e);
        @(posedge CLK);
        if (rn) begin
            if (!mw) begin
                if (iss_o && i.wen && i.dest != 0) begin
                    wb_at[i.dest] = act + 1 + WB_LAT;
                    is_ld[i.dest] = i.ld;
                end
                act++;
            end
            if (stl && m_sc < SCMAX) m_sc++;
            m_state = mw ? 2 : (haz ? 1 : 0);
        end
        #1;
    endtask

    function automatic ins_t mk(input bit v, input int rs, input int rt,
                                input bit urs, input bit urt, input bit wen,
                                input int dest, input bit ld);
        ins_t i;
        i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
        i.wen = wen; i.dest = 5'(dest); i.ld = ld;
        return i;
    endfunction

    task automatic hold(input ins_t i);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            step(i, 1'b0, 1'b0, 1'b1, got);
        end
    endtask

    initial begin
        ins_t nop;
        ins_t rd3;
        ins_t c;
        bit   got;
        bit   fl;
        bit   mw;
        bit   done;
        m_reset();
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rd3 = mk(1, 3, 0, 1, 0, 1, 9, 0);
        @(posedge CLK);
        #1;
        // reset with a valid reader of $5
        step(mk(1, 5, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, got);
        step(mk(1, 5, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, got);
        step(nop, 1'b0, 1'b0, 1'b1, got);
        // ALU RAW
        step(mk(1, 1, 2, 1, 1, 1, 3, 0), 1'b0, 1'b0, 1'b1, got);
        hold(rd3);
        // mem_wait in the middle of a hazard
        step(mk(1, 1, 2, 1, 1, 1, 3, 0), 1'b0, 1'b0, 1'b1, got);
        step(rd3, 1'b0, 1'b0, 1'b1, got);
        step(rd3, 1'b0, 1'b1, 1'b1, got);
        step(rd3, 1'b0, 1'b1, 1'b1, got);
        hold(rd3);
        // flush on a dependent, then $0 traffic
        step(mk(1, 1, 2, 1, 1, 1, 3, 0), 1'b0, 1'b0, 1'b1, got);
        step(rd3, 1'b1, 1'b0, 1'b1, got);
        hold(rd3);
        step(mk(1, 1, 2, 0, 0, 1, 0, 1), 1'b0, 1'b0, 1'b1, got);
        step(mk(1, 0, 0, 1, 1, 1, 6, 0), 1'b0, 1'b0, 1'b1, got);
        // WAW on $7
        step(mk(1, 1, 2, 0, 0, 1, 7, 0), 1'b0, 1'b0, 1'b1, got);
        step(mk(1, 1, 2, 0, 0, 1, 7, 1), 1'b0, 1'b0, 1'b1, got);
        hold(mk(1, 0, 7, 0, 1, 0, 0, 0));
        // load-use and ALU-use
        step(mk(1, 1, 2, 1, 0, 1, 4, 1), 1'b0, 1'b0, 1'b1, got);
        hold(mk(1, 0, 4, 0, 1, 1, 10, 0));
        step(mk(1, 1, 2, 1, 1, 1, 5, 0), 1'b0, 1'b0, 1'b1, got);
        hold(mk(1, 5, 0, 1, 0, 0, 0, 0));
        // reset while stalled discards pending writes
        step(mk(1, 1, 2, 0, 0, 1, 3, 0), 1'b0, 1'b0, 1'b1, got);
        step(rd3, 1'b0, 1'b0, 1'b1, got);
        step(rd3, 1'b0, 1'b0, 1'b0, got);
        step(rd3, 1'b0, 1'b0, 1'b1, got);
        // random traffic
        for (int n = 0; n < 500; n++) begin
            c = mk($urandom_range(0, 9) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 2) == 0);
            done = 1'b0;
            for (int k = 0; k < 12 && !done; k++) begin
                fl = ($urandom_range(0, 9) == 0);
                mw = ($urandom_range(0, 6) == 0);
                step(c, fl, mw, (n != 250), got);
                done = got || fl || !c.v;
            end
        end
        step(nop, 1'b0, 1'b0, 1'b1, got);
        repeat (2) @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
